// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges non-stallable ALU results and buffered memory results
// into one registered register-file write port, with per-read-port hazard flags.
module wb_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    input  logic        alu_byte,
    input  logic        mem_valid,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    input  logic        mem_byte,
    output logic        mem_ready,
    input  logic [4:0]  rreg1,
    input  logic [4:0]  rreg2,
    output logic        hazard1,
    output logic        hazard2,
    output logic [4:0]  wreg,
    output logic [31:0] wdata,
    output logic        w_en,
    output logic        w_byte
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [4:0]       ent_reg_q  [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [DEPTH-1:0] ent_byte_q;
    logic [DEPTH-1:0] ent_live_q;
    logic [PtrW-1:0]  head_q, tail_q;
    logic [CntW-1:0]  count_q;

    logic [4:0]  wreg_q;
    logic [31:0] wdata_q;
    logic        w_en_q, w_byte_q;

    logic alu_sel, fifo_empty, pop, bypass, push;

    assign alu_sel    = alu_valid && (alu_reg != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign mem_ready  = (count_q < CntW'(DEPTH));
    assign pop        = !alu_sel && !fifo_empty;
    assign bypass     = !alu_sel && fifo_empty && mem_valid && (mem_reg != 5'd0);
    // A mem result that reaches an empty FIFO with the ALU idle is bypassed or dropped.
    assign push       = mem_valid && mem_ready && (mem_reg != 5'd0) &&
                        !(!alu_sel && fifo_empty);

    assign wreg   = wreg_q;
    assign wdata  = wdata_q;
    assign w_en   = w_en_q;
    assign w_byte = w_byte_q;

    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ent_live_q[i] && (ent_reg_q[i] == rreg1)) hazard1 = 1'b1;
            if (ent_live_q[i] && (ent_reg_q[i] == rreg2)) hazard2 = 1'b1;
        end
        if (w_en_q && (wreg_q == rreg1)) hazard1 = 1'b1;
        if (w_en_q && (wreg_q == rreg2)) hazard2 = 1'b1;
        if (rreg1 == 5'd0) hazard1 = 1'b0;
        if (rreg2 == 5'd0) hazard2 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ent_live_q <= '0;
            w_en_q     <= 1'b0;
            wreg_q     <= 5'd0;
            wdata_q    <= 32'd0;
            w_byte_q   <= 1'b0;
        end else begin
            if (alu_sel) begin
                w_en_q   <= 1'b1;
                wreg_q   <= alu_reg;
                wdata_q  <= alu_data;
                w_byte_q <= alu_byte;
                // Older buffered writes to the same register are superseded.
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (ent_reg_q[i] == alu_reg) ent_live_q[i] <= 1'b0;
                end
            end else if (pop) begin
                w_en_q <= ent_live_q[head_q];
                if (ent_live_q[head_q]) begin
                    wreg_q   <= ent_reg_q[head_q];
                    wdata_q  <= ent_data_q[head_q];
                    w_byte_q <= ent_byte_q[head_q];
                end
                ent_live_q[head_q] <= 1'b0;
                head_q             <= head_q + PtrW'(1);
            end else if (bypass) begin
                w_en_q   <= 1'b1;
                wreg_q   <= mem_reg;
                wdata_q  <= mem_data;
                w_byte_q <= mem_byte;
            end else begin
                w_en_q <= 1'b0;
            end

            if (push) begin
                ent_reg_q[tail_q]  <= mem_reg;
                ent_data_q[tail_q] <= mem_data;
                ent_byte_q[tail_q] <= mem_byte;
                ent_live_q[tail_q] <= 1'b1;
                tail_q             <= tail_q + PtrW'(1);
            end

            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: reset, ALU path, back-pressure,
// WAW kill, byte bypass and mid-operation reset.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_byte, mem_valid, mem_byte, mem_ready;
    logic [4:0]  alu_reg, mem_reg, rreg1, rreg2, wreg;
    logic [31:0] alu_data, mem_data, wdata;
    logic        hazard1, hazard2, w_en, w_byte;

    int checks = 0;
    int errors = 0;

    logic [4:0] mregs     [5] = '{5'd3, 5'd4, 5'd6, 5'd7, 5'd8};
    logic       exp_ready [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_byte(alu_byte),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_byte(mem_byte),
        .mem_ready(mem_ready),
        .rreg1(rreg1), .rreg2(rreg2), .hazard1(hazard1), .hazard2(hazard2),
        .wreg(wreg), .wdata(wdata), .w_en(w_en), .w_byte(w_byte)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0; alu_byte = 1'b0;
        mem_valid = 1'b0; mem_reg = 5'd0; mem_data = 32'd0; mem_byte = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rreg1 = 5'd5; rreg2 = 5'd9;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (w_en !== 1'b0 || wreg !== 5'd0 || wdata !== 32'd0 || w_byte !== 1'b0) begin
                errors++;
                $display("FAIL reset_port cyc%0d: got w_en=%b wreg=%0d wdata=%h w_byte=%b, want 0",
                         i, w_en, wreg, wdata, w_byte);
            end
            checks++;
            if (mem_ready !== 1'b1 || hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags cyc%0d: got ready=%b h1=%b h2=%b, want 1 0 0",
                         i, mem_ready, hazard1, hazard2);
            end
            tick();
        end
    endtask

    task automatic test_alu();
        idle();
        rreg1 = 5'd5; rreg2 = 5'd0;
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h12345678;
        tick();
        idle();
        checks++;
        if (w_en !== 1'b1 || wreg !== 5'd5 || wdata !== 32'h12345678 || w_byte !== 1'b0) begin
            errors++;
            $display("FAIL alu_write: got w_en=%b wreg=%0d wdata=%h w_byte=%b, want 1 5 12345678 0",
                     w_en, wreg, wdata, w_byte);
        end
        checks++;
        if (hazard1 !== 1'b1) begin
            errors++;
            $display("FAIL alu_hazard: got %b want 1", hazard1);
        end
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hDEADBEEF;
        tick();
        idle();
        checks++;
        if (w_en !== 1'b0) begin
            errors++;
            $display("FAIL alu_r0_drop: got w_en=%b want 0", w_en);
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        logic [4:0]  er;
        logic [31:0] ed;
        idle();
        rreg1 = 5'd8; rreg2 = 5'd0;
        for (int c = 0; c < 11; c++) begin
            alu_valid = (c < 6);
            alu_reg   = 5'(20 + c);
            alu_data  = 32'hA000 + 32'(c);
            mem_valid = (idx < 5);
            if (idx < 5) begin
                mem_reg  = mregs[idx];
                mem_data = 32'h1000 + 32'(mregs[idx]);
            end
            if (c < 8) begin
                checks++;
                if (mem_ready !== exp_ready[c]) begin
                    errors++;
                    $display("FAIL b2b_ready cyc%0d: got %b want %b", c, mem_ready, exp_ready[c]);
                end
                if (exp_ready[c] && idx < 5) idx++;
            end
            tick();
            if (c < 6) begin
                er = 5'(20 + c);
                ed = 32'hA000 + 32'(c);
            end else begin
                er = mregs[c - 6];
                ed = 32'h1000 + 32'(mregs[c - 6]);
            end
            checks++;
            if (w_en !== 1'b1 || wreg !== er || wdata !== ed) begin
                errors++;
                $display("FAIL b2b_out cyc%0d: got w_en=%b wreg=%0d wdata=%h, want 1 %0d %h",
                         c, w_en, wreg, wdata, er, ed);
            end
        end
        idle();
        tick();
        checks++;
        if (w_en !== 1'b0 || hazard1 !== 1'b0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain: got w_en=%b h1=%b ready=%b, want 0 0 1",
                     w_en, hazard1, mem_ready);
        end
    endtask

    task automatic test_waw_kill();
        idle();
        rreg1 = 5'd9; rreg2 = 5'd10;
        alu_valid = 1'b1; alu_reg = 5'd10; alu_data = 32'h0BAD0BAD;
        mem_valid = 1'b1; mem_reg = 5'd9;  mem_data = 32'h000000AA;
        tick();
        idle();
        checks++;
        if (hazard1 !== 1'b1 || hazard2 !== 1'b1) begin
            errors++;
            $display("FAIL waw_buffered_hazard: got h1=%b h2=%b want 1 1", hazard1, hazard2);
        end
        alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h00000055;
        tick();
        idle();
        checks++;
        if (w_en !== 1'b1 || wreg !== 5'd9 || wdata !== 32'h55 || hazard1 !== 1'b1) begin
            errors++;
            $display("FAIL waw_alu_write: got w_en=%b wreg=%0d wdata=%h h1=%b, want 1 9 55 1",
                     w_en, wreg, wdata, hazard1);
        end
        tick();
        checks++;
        if (w_en !== 1'b0 || hazard1 !== 1'b0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL waw_dead_pop: got w_en=%b h1=%b ready=%b, want 0 0 1",
                     w_en, hazard1, mem_ready);
        end
        tick();
        checks++;
        if (w_en !== 1'b0) begin
            errors++;
            $display("FAIL waw_no_stale: got w_en=%b want 0", w_en);
        end
    endtask

    task automatic test_bypass_byte();
        idle();
        rreg1 = 5'd2; rreg2 = 5'd0;
        mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 32'h123456EF; mem_byte = 1'b1;
        tick();
        idle();
        checks++;
        if (w_en !== 1'b1 || w_byte !== 1'b1 || wreg !== 5'd2 || wdata[7:0] !== 8'hEF) begin
            errors++;
            $display("FAIL bypass_byte: got w_en=%b w_byte=%b wreg=%0d wdata=%h, want 1 1 2 xxxxxxEF",
                     w_en, w_byte, wreg, wdata);
        end
        checks++;
        if (mem_ready !== 1'b1 || hazard1 !== 1'b1) begin
            errors++;
            $display("FAIL bypass_flags: got ready=%b h1=%b want 1 1", mem_ready, hazard1);
        end
        mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'h11111111;
        tick();
        idle();
        checks++;
        if (w_en !== 1'b0 || hazard1 !== 1'b0) begin
            errors++;
            $display("FAIL bypass_empty_after: got w_en=%b h1=%b want 0 0", w_en, hazard1);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        rreg1 = 5'd11; rreg2 = 5'd13;
        for (int c = 0; c < 3; c++) begin
            alu_valid = 1'b1; alu_reg = 5'(24 + c); alu_data = 32'hC000 + 32'(c);
            mem_valid = 1'b1; mem_reg = 5'(11 + c); mem_data = 32'hB000 + 32'(c);
            tick();
        end
        idle();
        checks++;
        if (hazard1 !== 1'b1 || hazard2 !== 1'b1) begin
            errors++;
            $display("FAIL mid_filled: got h1=%b h2=%b want 1 1", hazard1, hazard2);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (w_en !== 1'b0 || hazard1 !== 1'b0 || hazard2 !== 1'b0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got w_en=%b h1=%b h2=%b ready=%b, want 0 0 0 1",
                     w_en, hazard1, hazard2, mem_ready);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (w_en !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_ghost cyc%0d: got w_en=%b wreg=%0d want w_en 0", i, w_en, wreg);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rreg1 = 5'd0; rreg2 = 5'd0;
        idle();
        test_reset();
        test_alu();
        test_back_to_back();
        test_waw_kill();
        test_bypass_byte();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback arbiter sitting directly upstream of the general-purpose register file write port. It merges two result streams into the single wreg/wdata/w_en/w_byte write port and presents them registered:
- single-cycle ALU results, which cannot stall;
- variable-latency memory/long-op results.

Memory results that lose arbitration are buffered in an in-order FIFO. Per-read-port hazard flags let decode stall until a pending write has landed.

Parameters:
DEPTH, 4, memory-result FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU result present this cycle
alu_reg  in  5  ALU destination register
alu_data  in  32  ALU result
alu_byte  in  1  ALU result is a byte write (low 8 bits only)
mem_valid  in  1  memory result offered
mem_reg  in  5  memory destination register
mem_data  in  32  memory result
mem_byte  in  1  memory result is a byte write
mem_ready  out  1  memory result accepted when mem_valid&&mem_ready
rreg1  in  5  decode read port 1 register number
rreg2  in  5  decode read port 2 register number
hazard1  out  1  write to rreg1 still pending
hazard2  out  1  write to rreg2 still pending
wreg  out  5  to register file write register
wdata  out  32  to register file write data
w_en  out  1  to register file write enable
w_byte  out  1  to register file byte-write select

Behaviour:
- Reset (synchronous, rst high at posedge):
  - FIFO emptied, count=0, all entry live bits cleared.
  - Output register: w_en=0, wreg=0, wdata=0, w_byte=0.
  - Reset mid-operation discards all buffered and in-flight writes.
- Output register: wreg/wdata/w_en/w_byte are flops. A result selected in cycle N appears on the write port in cycle N+1 and is written into the register file at the end of N+1.
- Selection priority each cycle (first match wins):
  1. alu_valid: select ALU.
  2. FIFO non-empty: pop head. Dead head drives w_en=0 but is still popped.
  3. mem_valid with FIFO empty: bypass, memory result selected directly and not enqueued.
  4. Otherwise: w_en=0; wreg/wdata/w_byte hold their previous values.
- Enqueue: a memory result is pushed when mem_valid && mem_ready and it was not bypassed. Push at tail; entry marked live.
- mem_ready = (count < DEPTH), combinational from registered count only.
  - Full FIFO gives mem_ready=0 even if a pop occurs the same cycle.
  - Push and pop in the same non-full cycle leave count unchanged.
- Ordering: memory results retire in acceptance order; pointers wrap modulo DEPTH.
- Register 0:
  - Any result with destination 0 is dropped at input: never enqueued, never drives w_en.
  - A dropped mem result still counts as accepted.
  - A dropped ALU result frees the slot for priorities 2/3 that cycle.
- WAW kill: when an ALU result to register X (X!=0) is selected, every live FIFO entry with dest X is marked dead in the same edge.
  - A mem result to X pushed that same cycle is younger and stays live.
  - Bypass never conflicts because ALU has priority.
- Hazards, combinational:
  - hazardK=1 iff rregK!=0 and either (a) any live FIFO entry has dest==rregK, or (b) w_en=1 and wreg==rregK.
  - Results arriving on the alu_*/mem_* inputs this cycle are not included; the upstream pipeline covers those.
- Byte writes: the byte flag travels with its data unchanged through the FIFO and bypass. Only wdata[7:0] is significant when w_byte=1.
- No combinational path from alu_*/mem_* to the write port.

Test Plan:
- Reset then idle → w_en=0, wreg=0, wdata=0, mem_ready=1, hazard1=hazard2=0 for 10 cycles.
- ALU writes r5=0x12345678 in cycle N → cycle N+1: w_en=1, wreg=5, wdata=0x12345678, w_byte=0. Repeat with alu_reg=0 → w_en stays 0.
- ALU busy 6 cycles; mem offers r3,r4,r6,r7,r8 back-to-back:
  - first 4 accepted; 5th held with mem_ready=0;
  - after ALU goes idle, writes emerge r3,r4,r6,r7 in order, one per cycle, then r8.
- Mem r9=0xAA buffered behind ALU traffic, then ALU writes r9=0x55 → FIFO entry dies. Register file sees only 0x55; the dead pop produces a w_en=0 cycle. hazard1 with rreg1=9 drops after the ALU write lands.
- Mem byte write r2 low byte 0xEF, alu idle, FIFO empty → bypass: next cycle w_en=1, w_byte=1, wreg=2, wdata[7:0]=0xEF, count stays 0.
- FIFO holds 3 entries, rst asserted one cycle → next cycle count=0, w_en=0, hazards 0, mem_ready=1. No buffered write ever appears.
